vga_timing_gen: RTL and testbench

//  Raster timing generator for the 640x480@60 VGA display path; drives color_mapper.

---
 rtl/vga_timing_gen.sv | 138 +++++++++++++
 tb/tb_vga_timing_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator for the 640x480@60 VGA path: pixel enable, syncs, blank, draw position, frame pulse.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN; otherwise frame_cnt is tied to zero.
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        Clk,
    input  logic        Reset_n,
    output logic        pixel_clk,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        sync,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_r;
    logic [9:0]       hc_r;
    logic [9:0]       vc_r;
    logic             frame_start_r;
    logic             pix_en_s;
    logic             h_wrap_s;
    logic             v_wrap_s;
    logic             frame_wrap_s;
    logic             hs_s;
    logic             vs_s;
    logic             blank_s;

    // Reset gating keeps pixel_clk low while held in reset even when CLK_DIV is 1.
    assign pix_en_s     = (div_r == DIV_W'(CLK_DIV - 1)) && Reset_n;
    assign h_wrap_s     = (hc_r == 10'(H_TOTAL - 1));
    assign v_wrap_s     = (vc_r == 10'(V_TOTAL - 1));
    assign frame_wrap_s = pix_en_s && h_wrap_s && v_wrap_s;

    // Clock divider producing the pixel-rate enable
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_r <= {DIV_W{1'b0}};
        end else if (pix_en_s) begin
            div_r <= {DIV_W{1'b0}};
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Horizontal and vertical raster counters
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hc_r <= 10'd0;
            vc_r <= 10'd0;
        end else if (pix_en_s) begin
            if (h_wrap_s) begin
                hc_r <= 10'd0;
                vc_r <= v_wrap_s ? 10'd0 : (vc_r + 10'd1);
            end else begin
                hc_r <= hc_r + 10'd1;
                vc_r <= vc_r;
            end
        end else begin
            hc_r <= hc_r;
            vc_r <= vc_r;
        end
    end

    // One-cycle frame pulse, high during the first cycle of hc=vc=0
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= frame_wrap_s;
        end
    end

    // Sync and blank decodes from the registered counters
    always_comb begin
        hs_s    = 1'b1;
        vs_s    = 1'b1;
        blank_s = 1'b0;
        if ((hc_r >= 10'(H_VISIBLE + H_FP)) && (hc_r < 10'(H_VISIBLE + H_FP + H_SYNC))) begin
            hs_s = 1'b0;
        end else begin
            hs_s = 1'b1;
        end
        if ((vc_r >= 10'(V_VISIBLE + V_FP)) && (vc_r < 10'(V_VISIBLE + V_FP + V_SYNC))) begin
            vs_s = 1'b0;
        end else begin
            vs_s = 1'b1;
        end
        if ((hc_r < 10'(H_VISIBLE)) && (vc_r < 10'(V_VISIBLE))) begin
            blank_s = 1'b1;
        end else begin
            blank_s = 1'b0;
        end
    end

    assign pixel_clk   = pix_en_s;
    assign hs          = hs_s;
    assign vs          = vs_s;
    assign blank       = blank_s;
    assign sync        = 1'b0;
    assign DrawX       = hc_r;
    assign DrawY       = vc_r;
    assign frame_start = frame_start_r;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Frames since reset, stepping on the same edge that raises frame_start
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_cnt_r <= 16'h0;
        end else if (frame_wrap_s) begin
            frame_cnt_r <= frame_cnt_r + 16'h1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`else
    assign frame_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-geometry instance for line timing, two small-geometry
// instances (CLK_DIV=1 and CLK_DIV=3) for multi-frame and reset corner cases.
module tb_vga_timing_gen;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    logic        d_pix, d_hs, d_vs, d_blank, d_sync, d_fs;
    logic [9:0]  d_x, d_y;
    logic [15:0] d_fc;
    logic        s_pix, s_hs, s_vs, s_blank, s_sync, s_fs;
    logic [9:0]  s_x, s_y;
    logic [15:0] s_fc;
    logic        t_pix, t_hs, t_vs, t_blank, t_sync, t_fs;
    logic [9:0]  t_x, t_y;
    logic [15:0] t_fc;

    vga_timing_gen u_def (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_clk(d_pix), .hs(d_hs), .vs(d_vs), .blank(d_blank),
        .sync(d_sync), .DrawX(d_x), .DrawY(d_y), .frame_start(d_fs), .frame_cnt(d_fc));

    vga_timing_gen #(.CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(3)) u_sm (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_clk(s_pix), .hs(s_hs), .vs(s_vs), .blank(s_blank),
        .sync(s_sync), .DrawX(s_x), .DrawY(s_y), .frame_start(s_fs), .frame_cnt(s_fc));

    vga_timing_gen #(.CLK_DIV(3), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(3)) u_sm3 (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_clk(t_pix), .hs(t_hs), .vs(t_vs), .blank(t_blank),
        .sync(t_sync), .DrawX(t_x), .DrawY(t_y), .frame_start(t_fs), .frame_cnt(t_fc));

    typedef struct {
        int   n;
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic blank;
        logic pix;
    } vec_t;

    vec_t tbl[14];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Small geometry: H_TOTAL 15 (hs low 10..12, visible <8), V_TOTAL 12 (vs low 7..8, visible <6)
    task automatic chk_small(input int n);
        int hc, vc, p;
        hc = n % 15;
        vc = (n / 15) % 12;
        chk("sm_x", int'(s_x), hc);
        chk("sm_y", int'(s_y), vc);
        chk("sm_hs", int'(s_hs), (hc >= 10 && hc <= 12) ? 0 : 1);
        chk("sm_vs", int'(s_vs), (vc >= 7 && vc <= 8) ? 0 : 1);
        chk("sm_blank", int'(s_blank), (hc < 8 && vc < 6) ? 1 : 0);
        chk("sm_pix", int'(s_pix), 1);
        chk("sm_fs", int'(s_fs), (n > 0 && n % 180 == 0) ? 1 : 0);
        p  = n / 3;
        hc = p % 15;
        vc = (p / 15) % 12;
        chk("sm3_x", int'(t_x), hc);
        chk("sm3_y", int'(t_y), vc);
        chk("sm3_hs", int'(t_hs), (hc >= 10 && hc <= 12) ? 0 : 1);
        chk("sm3_vs", int'(t_vs), (vc >= 7 && vc <= 8) ? 0 : 1);
        chk("sm3_blank", int'(t_blank), (hc < 8 && vc < 6) ? 1 : 0);
        chk("sm3_pix", int'(t_pix), (n % 3 == 2) ? 1 : 0);
        chk("sm3_fs", int'(t_fs), (n > 0 && n % 540 == 0) ? 1 : 0);
    endtask

    initial begin
        int ti;
        int hs_low_pix, hs_low_cyc, t_vs_low, s_pulses, t_pulses, t_last;
        int exp_s_fc, exp_t_fc;

        tbl[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{2,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{3,    1,   0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{4,    2,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1278, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1280, 640, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1311, 655, 0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1312, 656, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1503, 751, 0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1504, 752, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1599, 799, 0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1600, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1625, 12,  1, 1'b1, 1'b1, 1'b1, 1'b1};

`ifdef VGA_FRAME_CNT_EN
        exp_s_fc = 9;
        exp_t_fc = 3;
`else
        exp_s_fc = 0;
        exp_t_fc = 0;
`endif

        // Values held during reset
        repeat (3) @(negedge Clk);
        #1;
        chk("rst_x", int'(d_x), 0);
        chk("rst_y", int'(d_y), 0);
        chk("rst_hs", int'(d_hs), 1);
        chk("rst_vs", int'(d_vs), 1);
        chk("rst_blank", int'(d_blank), 1);
        chk("rst_pix", int'(d_pix), 0);
        chk("rst_pix_div1", int'(s_pix), 0);
        chk("rst_fs", int'(d_fs), 0);
        chk("rst_fc", int'(d_fc), 0);
        chk("rst_sync", int'(d_sync), 0);

        // Main run: 1626 samples covering one default line and three CLK_DIV=3 frames
        ti = 0; hs_low_pix = 0; hs_low_cyc = 0; t_vs_low = 0;
        s_pulses = 0; t_pulses = 0; t_last = 0;
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int n = 0; n <= 1625; n++) begin
            if (n > 0) @(negedge Clk);
            #1;
            chk_small(n);
            chk("def_fs", int'(d_fs), 0);
            chk("def_sync", int'(d_sync), 0);
            if (n < 1600 && d_hs == 1'b0) begin
                hs_low_cyc++;
                if (d_pix) hs_low_pix++;
            end
            if (t_vs == 1'b0) t_vs_low++;
            if (s_fs) s_pulses++;
            if (t_fs) begin
                t_pulses++;
                if (t_pulses > 1) chk("sm3_fs_spacing", n - t_last, 540);
                chk("sm3_fs_at_origin", int'(t_x) + int'(t_y), 0);
                t_last = n;
            end
            if (ti < 14 && tbl[ti].n == n) begin
                chk($sformatf("def_x@%0d", n), int'(d_x), tbl[ti].x);
                chk($sformatf("def_y@%0d", n), int'(d_y), tbl[ti].y);
                chk($sformatf("def_hs@%0d", n), int'(d_hs), int'(tbl[ti].hs));
                chk($sformatf("def_vs@%0d", n), int'(d_vs), int'(tbl[ti].vs));
                chk($sformatf("def_blank@%0d", n), int'(d_blank), int'(tbl[ti].blank));
                chk($sformatf("def_pix@%0d", n), int'(d_pix), int'(tbl[ti].pix));
                ti++;
            end
        end
        chk("tbl_all_applied", ti, 14);
        chk("def_hs_low_pixels", hs_low_pix, 96);
        chk("def_hs_low_cycles", hs_low_cyc, 192);
        chk("sm3_vs_low_cycles", t_vs_low, 270);
        chk("sm_pulses", s_pulses, 9);
        chk("sm3_pulses", t_pulses, 3);
        chk("sm_frame_cnt", int'(s_fc), exp_s_fc);
        chk("sm3_frame_cnt", int'(t_fc), exp_t_fc);
        chk("def_frame_cnt", int'(d_fc), 0);

        // Reset mid-frame while hs and vs are both low (hc=11, vc=7)
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (116) @(negedge Clk);
        #1;
        chk("pre_rst_hs", int'(s_hs), 0);
        chk("pre_rst_vs", int'(s_vs), 0);
        chk("pre_rst_x", int'(s_x), 11);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_x", int'(s_x), 0);
        chk("mid_rst_y", int'(s_y), 0);
        chk("mid_rst_hs", int'(s_hs), 1);
        chk("mid_rst_vs", int'(s_vs), 1);
        chk("mid_rst_def_x", int'(d_x), 0);

        // Reset asserted while frame_start is high
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (180) @(negedge Clk);
        #1;
        chk("pulse_before_rst", int'(s_fs), 1);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("pulse_cleared_by_rst", int'(s_fs), 0);
        chk("fc_cleared_by_rst", int'(s_fc), 0);
        @(negedge Clk);
        #1;
        chk("held_rst_fs", int'(s_fs), 0);
        chk("held_rst_x", int'(s_x), 0);

        // Counting resumes on the first edge after release
        Reset_n = 1'b1;
        @(negedge Clk);
        #1;
        chk("resume_sm_x", int'(s_x), 1);
        chk("resume_sm_fs", int'(s_fs), 0);
        chk("resume_def_x", int'(d_x), 0);
        chk("resume_def_pix", int'(d_pix), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
